mmcm_lock_sequencer: RTL and testbench
======================================

# mmcm_lock_sequencer

Reset and lock sequencer for the board's MMCME2_ADV clock generator. It runs on the free-running input clock, upstream of the MMCM. It drives the MMCM `RST` pin, watches `LOCKED`, and releases a synchronous reset to logic in the generated clock domains only after lock has been stable for a programmed time. It retries on lock timeout, re-sequences on loss of lock, and latches a hard failure after too many retries.

## Interface
- `RST_CYCLES`, 16: cycles `mmcm_rst` is held high per reset pulse (≥1).
- `LOCK_TIMEOUT`, 200000: cycles to wait for lock after `mmcm_rst` falls (1 ms at 200 MHz; ≥1).
- `STABLE_CYCLES`, 1024: consecutive locked cycles required before release (≥1).
- `MAX_RETRIES`, 3: timeouts tolerated before FAIL (0..15).
- `clk`  in  1  free-running MMCM input clock (post-IBUFDS).
- `rst`  in  1  asynchronous, active-high reset.
- `locked_in`  in  1  MMCM `LOCKED`; asynchronous to `clk`.
- `mmcm_rst`  out  1  to MMCM `RST`.
- `sys_rst_out`  out  1  active-high reset for downstream clock domains.
- `ready`  out  1  high only in RUN.
- `fail`  out  1  high only in FAIL.
- `retry_count`  out  4  timeouts in the current lock attempt.
- `lock_loss_count`  out  8  lock losses seen in RUN; saturates at 255.
- `state`  out  3  RESET_HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

## Operation
- One clock (`clk`). Reset is asynchronous and active-high (`rst`).
- `locked_in` passes through a 2-flop synchronizer; the second flop is `locked_s`. Both flops clear on `rst`.
- A single cycle counter serves every state. It clears on every state transition. Width is clog2 of max(`RST_CYCLES`, `LOCK_TIMEOUT`, `STABLE_CYCLES`) + 1.
- **RESET_HOLD:**
  - `mmcm_rst`=1.
  - After `RST_CYCLES` cycles in the state, go to WAIT_LOCK.
- **WAIT_LOCK:**
  - `mmcm_rst`=0.
  - If `locked_s`=1, go to STABLE.
  - Otherwise, when the counter reaches `LOCK_TIMEOUT`-1: if `retry_count`==`MAX_RETRIES`, go to FAIL; else increment `retry_count` and go to RESET_HOLD.
- **STABLE:**
  - If `locked_s`=0, go to WAIT_LOCK. This is a glitch, so there is no MMCM reset and `retry_count` is unchanged.
  - Otherwise, after `STABLE_CYCLES` consecutive cycles, go to RUN and clear `retry_count`.
- **RUN:**
  - `sys_rst_out`=0, `ready`=1.
  - If `locked_s`=0, increment `lock_loss_count` (saturating) and go to RESET_HOLD.
- **FAIL:**
  - `mmcm_rst`=1, `sys_rst_out`=1, `fail`=1.
  - Terminal: leaves only on `rst`.
- Outside RUN: `sys_rst_out`=1, `ready`=0.
- Simultaneous events:
  - Lock and timeout on the same WAIT_LOCK cycle: lock wins.
  - Lock drop on the same cycle STABLE completes: drop wins, go to WAIT_LOCK.
- `rst` mid-operation: all state, counters and outputs return to reset values immediately.

## Timing
- Reset values: `state`=RESET_HOLD, `mmcm_rst`=1, `sys_rst_out`=1, `ready`=0, `fail`=0, `retry_count`=0, `lock_loss_count`=0, synchronizer=0.
- All outputs are registered and decoded from next state, so they change on the same edge as `state`. There are no combinational paths from input to output.
- `mmcm_rst` high time:
  - After `rst` deassert: exactly `RST_CYCLES` rising edges; it falls on edge `RST_CYCLES`.
  - On each retry or lock loss: exactly `RST_CYCLES` cycles.
- `locked_in` rise to entering STABLE: 3 edges (2 synchronizer + 1 FSM).
- `locked_in` rise to `sys_rst_out` fall, given no glitch: 3 + `STABLE_CYCLES` edges.
- `locked_in` fall in RUN to `sys_rst_out`/`mmcm_rst` rise and `ready` fall: 3 edges. A low pulse of ≥2 cycles is guaranteed to be caught.
- Timeout: a FAIL or retry decision occurs `LOCK_TIMEOUT` cycles after entering WAIT_LOCK.

## Test plan
Bench parameters: `RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `MAX_RETRIES`=2.

1. **Normal bring-up.**
   - Stimulus: release `rst`; raise `locked_in` 10 cycles after `mmcm_rst` falls.
   - Response: `mmcm_rst` falls at edge 4. `sys_rst_out` falls and `ready` rises 11 edges after `locked_in` rises. `retry_count`=0.
2. **Never locks.**
   - Stimulus: hold `locked_in`=0.
   - Response: three `mmcm_rst` pulses of 4 cycles each, separated by 20-cycle waits. `fail`=1 and `state`=4 after the third timeout. `retry_count`=2. `mmcm_rst` then stays high.
3. **Lock loss in RUN.**
   - Stimulus: drop `locked_in` for 3 cycles, then restore it.
   - Response: 3 edges after the drop, `sys_rst_out`=1, `ready`=0, `lock_loss_count`=1. `mmcm_rst` pulses for 4 cycles, then the block returns to RUN.
4. **Glitch in STABLE.**
   - Stimulus: drop `locked_in` for 2 cycles after 5 stable cycles.
   - Response: the block returns to WAIT_LOCK with no `mmcm_rst` pulse and `retry_count` unchanged. The STABLE count restarts, so the full 8 cycles are required again.
5. **Async reset.**
   - Stimulus: assert `rst` between clock edges during WAIT_LOCK, with `retry_count`=1.
   - Response: all outputs take their reset values before the next edge; `retry_count`=0.
6. **Tie.**
   - Stimulus: `locked_s` rises on counter value 19 of WAIT_LOCK.
   - Response: `state`=STABLE, with no retry increment and no `mmcm_rst` pulse.

Source files
------------

// File: rtl/mmcm_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mmcm_lock_sequencer
// Purpose  : Drives MMCM RST, qualifies LOCKED, releases downstream reset,
//            retries on lock timeout and latches a hard failure.
// Revision : 1.0 - initial release
// ============================================================================
module mmcm_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 200000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked_in,
    output logic       mmcm_rst,
    output logic       sys_rst_out,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);

    localparam int c_MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_CNT_MAX = (c_MAX_A > STABLE_CYCLES) ? c_MAX_A : STABLE_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_RST_LAST    = c_CNT_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]         c_MAX_RETRIES = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABLE     = 3'd2,
        S_RUN        = 3'd3,
        S_FAIL       = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_sync1;
    logic                 r_locked_s;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [3:0]           r_retry;
    logic [3:0]           w_next_retry;
    logic [7:0]           r_loss;
    logic [7:0]           w_next_loss;
    logic                 w_state_change;
    logic                 w_counting;

    // LOCKED comes from another clock domain; two flops before any use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_sync1    <= locked_in;
            r_locked_s <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RESET_HOLD;
            r_retry <= 4'd0;
            r_loss  <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_retry <= w_next_retry;
            r_loss  <= w_next_loss;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_retry = r_retry;
        w_next_loss  = r_loss;
        case (r_state)
            S_RESET_HOLD: begin
                if (r_cnt == c_RST_LAST)
                    w_next_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (r_locked_s) begin
                    w_next_state = S_STABLE;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    if (r_retry == c_MAX_RETRIES) begin
                        w_next_state = S_FAIL;
                    end else begin
                        w_next_retry = r_retry + 4'd1;
                        w_next_state = S_RESET_HOLD;
                    end
                end
            end
            S_STABLE: begin
                if (!r_locked_s) begin
                    w_next_state = S_WAIT_LOCK;
                end else if (r_cnt == c_STABLE_LAST) begin
                    w_next_state = S_RUN;
                    w_next_retry = 4'd0;
                end
            end
            S_RUN: begin
                if (!r_locked_s) begin
                    w_next_state = S_RESET_HOLD;
                    if (r_loss != 8'hFF)
                        w_next_loss = r_loss + 8'd1;
                end
            end
            S_FAIL: begin
                w_next_state = S_FAIL;
            end
            default: begin
                w_next_state = S_RESET_HOLD;
            end
        endcase
    end

    assign w_state_change = (w_next_state != r_state);
    assign w_counting     = (r_state == S_RESET_HOLD) || (r_state == S_WAIT_LOCK) ||
                            (r_state == S_STABLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (w_state_change)
            r_cnt <= '0;
        else if (w_counting)
            r_cnt <= r_cnt + 1'b1;
    end

    // Outputs decode the next state so they move on the same edge as state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mmcm_rst    <= 1'b1;
            sys_rst_out <= 1'b1;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            mmcm_rst    <= (w_next_state == S_RESET_HOLD) || (w_next_state == S_FAIL);
            sys_rst_out <= (w_next_state != S_RUN);
            ready       <= (w_next_state == S_RUN);
            fail        <= (w_next_state == S_FAIL);
        end
    end

    assign retry_count     = r_retry;
    assign lock_loss_count = r_loss;
    assign state           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mmcm_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmcm_lock_sequencer
// Purpose  : Directed bench with a phase/countdown reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmcm_lock_sequencer;

    localparam int c_RST    = 4;
    localparam int c_TO     = 20;
    localparam int c_STABLE = 8;
    localparam int c_MAXR   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked_in = 1'b0;
    logic       mmcm_rst;
    logic       sys_rst_out;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;
    int ecnt  = 0;
    bit m_valid = 1'b0;

    mmcm_lock_sequencer #(
        .RST_CYCLES   (c_RST),
        .LOCK_TIMEOUT (c_TO),
        .STABLE_CYCLES(c_STABLE),
        .MAX_RETRIES  (c_MAXR)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .locked_in      (locked_in),
        .mmcm_rst       (mmcm_rst),
        .sys_rst_out    (sys_rst_out),
        .ready          (ready),
        .fail           (fail),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count),
        .state          (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    // Reference model: phase number plus cycles remaining in that phase.
    int m_ph, m_rem, m_retries, m_loss;
    bit m_s1, m_s2;
    always @(posedge clk or posedge rst) begin
        bit ls;
        if (rst) begin
            m_ph = 0; m_rem = c_RST; m_retries = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            ls = m_s2;
            m_s2 = m_s1;
            m_s1 = locked_in;
            case (m_ph)
                0: begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin m_ph = 1; m_rem = c_TO; end
                end
                1: begin
                    if (ls) begin
                        m_ph = 2; m_rem = c_STABLE;
                    end else begin
                        m_rem = m_rem - 1;
                        if (m_rem == 0) begin
                            if (m_retries == c_MAXR) m_ph = 4;
                            else begin m_retries++; m_ph = 0; m_rem = c_RST; end
                        end
                    end
                end
                2: begin
                    if (!ls) begin
                        m_ph = 1; m_rem = c_TO;
                    end else begin
                        m_rem = m_rem - 1;
                        if (m_rem == 0) begin m_ph = 3; m_retries = 0; end
                    end
                end
                3: begin
                    if (!ls) begin
                        if (m_loss < 255) m_loss++;
                        m_ph = 0; m_rem = c_RST;
                    end
                end
                default: m_ph = 4;
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, ecnt, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid) begin
            check("model state",   int'(state),           m_ph);
            check("model mmcm_rst", int'(mmcm_rst),       (m_ph == 0 || m_ph == 4) ? 1 : 0);
            check("model sys_rst", int'(sys_rst_out),     (m_ph != 3) ? 1 : 0);
            check("model ready",   int'(ready),           (m_ph == 3) ? 1 : 0);
            check("model fail",    int'(fail),            (m_ph == 4) ? 1 : 0);
            check("model retry",   int'(retry_count),     m_retries);
            check("model loss",    int'(lock_loss_count), m_loss);
        end
    end

    task automatic at_edge(input int n);
        while (ecnt < n) @(negedge clk);
    endtask

    task automatic do_reset(input logic lk);
        rst = 1'b1;
        locked_in = lk;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " state"},    int'(state), 0);
        check({tag, " mmcm_rst"}, int'(mmcm_rst), 1);
        check({tag, " sys_rst"},  int'(sys_rst_out), 1);
        check({tag, " ready"},    int'(ready), 0);
        check({tag, " fail"},     int'(fail), 0);
        check({tag, " retry"},    int'(retry_count), 0);
        check({tag, " loss"},     int'(lock_loss_count), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", ecnt);
        $fatal(1, "watchdog");
    end

    initial begin
        // Normal bring-up
        do_reset(1'b0);
        check_reset_values("reset");
        at_edge(3);  check("bringup mmcm_rst e3", int'(mmcm_rst), 1);
        at_edge(4);  check("bringup mmcm_rst e4", int'(mmcm_rst), 0);
                     check("bringup state e4", int'(state), 1);
        at_edge(14); locked_in = 1'b1;
        at_edge(17); check("bringup state e17", int'(state), 2);
        at_edge(24); check("bringup ready e24", int'(ready), 0);
                     check("bringup sys_rst e24", int'(sys_rst_out), 1);
        at_edge(25); check("bringup ready e25", int'(ready), 1);
                     check("bringup sys_rst e25", int'(sys_rst_out), 0);
                     check("bringup retry", int'(retry_count), 0);

        // Lock loss in RUN
        at_edge(30); locked_in = 1'b0;
        at_edge(32); check("loss ready e32", int'(ready), 1);
        at_edge(33); check("loss sys_rst e33", int'(sys_rst_out), 1);
                     check("loss ready e33", int'(ready), 0);
                     check("loss count e33", int'(lock_loss_count), 1);
                     check("loss mmcm_rst e33", int'(mmcm_rst), 1);
                     locked_in = 1'b1;
        at_edge(36); check("loss mmcm_rst e36", int'(mmcm_rst), 1);
        at_edge(37); check("loss mmcm_rst e37", int'(mmcm_rst), 0);
        at_edge(38); check("loss state e38", int'(state), 2);
        at_edge(45); check("loss state e45", int'(state), 2);
        at_edge(46); check("loss state e46", int'(state), 3);

        // Glitch in STABLE
        do_reset(1'b1);
        at_edge(5);  check("glitch state e5", int'(state), 2);
        at_edge(10); locked_in = 1'b0;
        at_edge(12); locked_in = 1'b1;
                     check("glitch state e12", int'(state), 2);
        at_edge(13); check("glitch state e13", int'(state), 1);
                     check("glitch mmcm_rst e13", int'(mmcm_rst), 0);
        at_edge(15); check("glitch state e15", int'(state), 2);
        at_edge(22); check("glitch state e22", int'(state), 2);
        at_edge(23); check("glitch state e23", int'(state), 3);

        // Lock and timeout on the same cycle
        do_reset(1'b0);
        at_edge(21); locked_in = 1'b1;
        at_edge(23); check("tie state e23", int'(state), 1);
        at_edge(24); check("tie state e24", int'(state), 2);
                     check("tie retry e24", int'(retry_count), 0);
                     check("tie mmcm_rst e24", int'(mmcm_rst), 0);
        at_edge(32); check("tie state e32", int'(state), 3);

        // Async reset mid-WAIT_LOCK
        do_reset(1'b0);
        at_edge(30); check("async pre retry", int'(retry_count), 1);
                     check("async pre state", int'(state), 1);
        #2 rst = 1'b1;
        #1 check_reset_values("async");

        // Never locks
        do_reset(1'b0);
        at_edge(23); check("nolock state e23", int'(state), 1);
        at_edge(24); check("nolock state e24", int'(state), 0);
                     check("nolock retry e24", int'(retry_count), 1);
        at_edge(27); check("nolock mmcm_rst e27", int'(mmcm_rst), 1);
        at_edge(28); check("nolock mmcm_rst e28", int'(mmcm_rst), 0);
        at_edge(48); check("nolock retry e48", int'(retry_count), 2);
        at_edge(71); check("nolock fail e71", int'(fail), 0);
        at_edge(72); check("nolock state e72", int'(state), 4);
                     check("nolock fail e72", int'(fail), 1);
                     check("nolock mmcm_rst e72", int'(mmcm_rst), 1);
                     check("nolock retry e72", int'(retry_count), 2);
        at_edge(100); check("nolock state e100", int'(state), 4);
                      check("nolock mmcm_rst e100", int'(mmcm_rst), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
